// File: rtl/mos6502_bus_pkg.sv
// Shared types and constants for the MOS6502 external-bus models.
// Holds the bus FSM state encoding, vector addresses and a map-decode helper.
package mos6502_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } bus_state_e;

    localparam logic [15:0] VEC_RES_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RES_HI = 16'hFFFD;
    localparam logic [7:0]  OPC_NOP    = 8'hEA;

    // True when addr falls inside a 2**addr_w byte array based at address 0.
    function automatic logic addr_mapped(input logic [15:0] addr, input int unsigned addr_w);
        return ({1'b0, addr} < (17'd1 << addr_w));
    endfunction

endpackage

// File: rtl/phi2_edge_det.sv
// Registers phi2 in the system clock domain and flags its rising and falling edges.
// Shared by the memory responder and the bus monitor.
module phi2_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_phi2,
    output logic o_rise,
    output logic o_fall
);

    logic r_phi2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phi2_q <= 1'b0;
        end else begin
            r_phi2_q <= i_phi2;
        end
    end

    assign o_rise = i_phi2 & ~r_phi2_q;
    assign o_fall = ~i_phi2 & r_phi2_q;

endmodule

// File: rtl/mos6502_mem_responder.sv
// Memory-side target for the 6502 ab/db/rw bus, clocked by a fast clk with phi2 as data.
// Optional write protection below ROM_TOP is enabled by defining MOS6502_MEM_ROM_WP_EN.
module mos6502_mem_responder
    import mos6502_bus_pkg::*;
#(
    parameter int          ADDR_W    = 9,
    parameter logic [7:0]  FILL_BYTE = 8'hFF,
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter int          HOLD_CYC  = 2,
    parameter int          CNT_W     = 32
`ifdef MOS6502_MEM_ROM_WP_EN
    ,
    parameter logic [15:0] ROM_TOP   = 16'h0100
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             phi2,
    input  logic [15:0]      ab,
    input  logic             rw,
    input  logic             sync,
    input  logic [7:0]       db_in,
    output logic [7:0]       db_out,
    output logic             db_oe,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] wr_cnt,
`ifdef MOS6502_MEM_ROM_WP_EN
    output logic [CNT_W-1:0] wp_viol_cnt,
`endif
    output logic             busy
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;
    localparam int HOLD_W    = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    bus_state_e        r_state;
    logic [15:0]       r_addr;
    logic              r_rw;
    logic              r_sync;
    logic [7:0]        r_wdata;
    logic [HOLD_W-1:0] r_hold;
    logic [7:0]        r_db_out;
    logic              r_db_oe;
    logic [CNT_W-1:0]  r_cyc_cnt;
    logic [CNT_W-1:0]  r_fetch_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [7:0]        r_mem [0:MEM_DEPTH-1];

    logic       w_rise;
    logic       w_fall;
    logic       w_start;
    logic       w_cyc_end;
    logic       w_mapped;
    logic       w_wp;
    logic       w_commit;
    logic       w_mem_we;
    logic [7:0] w_rd_data;

    phi2_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_phi2 (phi2),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // A new cycle may begin from IDLE or cut a data hold short.
    assign w_start   = w_rise & ((r_state == IDLE) | (r_state == HOLD));
    assign w_cyc_end = w_fall & ((r_state == READ) | (r_state == WRITE));
    assign w_mapped  = addr_mapped(r_addr, ADDR_W);

`ifdef MOS6502_MEM_ROM_WP_EN
    assign w_wp = (r_addr < ROM_TOP);
`else
    assign w_wp = 1'b0;
`endif

    // Gating with reset discards a write whose fall coincides with reset.
    assign w_commit = (r_state == WRITE) & w_fall & ~reset;
    assign w_mem_we = w_commit & w_mapped & ~w_wp;

    always_comb begin
        w_rd_data = FILL_BYTE;
        if (r_addr == VEC_RES_LO) begin
            w_rd_data = RESET_VEC[7:0];
        end else if (r_addr == VEC_RES_HI) begin
            w_rd_data = RESET_VEC[15:8];
        end else if (w_mapped) begin
            w_rd_data = r_mem[r_addr[ADDR_W-1:0]];
        end
    end

    // NOTE: the array has no reset branch so it maps onto plain RAM and survives a CPU reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr[ADDR_W-1:0]] <= r_wdata;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= 16'h0000;
            r_rw        <= 1'b1;
            r_sync      <= 1'b0;
            r_wdata     <= 8'h00;
            r_hold      <= '0;
            r_db_out    <= 8'h00;
            r_db_oe     <= 1'b0;
            r_cyc_cnt   <= '0;
            r_fetch_cnt <= '0;
            r_wr_cnt    <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= ab;
                r_rw    <= rw;
                r_sync  <= sync;
                r_wdata <= db_in;
            end

            if (w_cyc_end) begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
                if (r_sync) begin
                    r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
                end
            end

            if (w_mem_we) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= rw ? READ : WRITE;
                    end
                end
                READ: begin
                    r_db_out <= w_rd_data;
                    r_db_oe  <= 1'b1;
                    if (w_fall) begin
                        if (HOLD_CYC == 0) begin
                            r_db_oe <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_hold  <= HOLD_LOAD;
                            r_state <= HOLD;
                        end
                    end
                end
                WRITE: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                    end else begin
                        r_wdata <= db_in;
                    end
                end
                HOLD: begin
                    if (w_rise) begin
                        r_state <= rw ? READ : WRITE;
                        r_db_oe <= rw;
                    end else if (r_hold == '0) begin
                        r_db_oe <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MOS6502_MEM_ROM_WP_EN
    logic [CNT_W-1:0] r_wp_viol_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp_viol_cnt <= '0;
        end else if (w_commit && w_wp) begin
            r_wp_viol_cnt <= r_wp_viol_cnt + CNT_W'(1);
        end
    end

    assign wp_viol_cnt = r_wp_viol_cnt;
`endif

    assign db_out    = r_db_out;
    assign db_oe     = r_db_oe;
    assign cyc_cnt   = r_cyc_cnt;
    assign fetch_cnt = r_fetch_cnt;
    assign wr_cnt    = r_wr_cnt;
    assign busy      = (r_state != IDLE);

endmodule
